sipo_pad_buffer: RTL and testbench

- Upstream absorb-side stage of the SHAKE datapath.
- Collects WIDTH-bit message words over a valid/ready handshake into one rate block of DEPTH words.
- Applies SHAKE padding (domain byte 0x1F, final bit 0x80) on the last word, then presents the full block with a valid/ready handshake to the permutation/state-XOR logic.
- Its packed block layout is the one the parallel-load shift-out buffer expects: the first word received occupies the top slice.

---
 rtl/sipo_pad_buffer.sv | 144 ++++++++++++++
 tb/tb_sipo_pad_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_pad_buffer.sv
// SHAKE absorb-side collector: gathers message words into one rate block,
// applies SHAKE padding on the last word and hands the block downstream.
module sipo_pad_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 21
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_valid,
    input  logic                           in_last,
    input  logic [$clog2(WIDTH/8+1)-1:0]   in_bytes,
    output logic                           in_ready,
    output logic [DEPTH*WIDTH-1:0]         block_out,
    output logic                           block_valid,
    output logic                           block_last,
    input  logic                           block_ready
);

    localparam int NB = WIDTH / 8;
    localparam int IW = $clog2(DEPTH);

    localparam logic [WIDTH-1:0] PAD_LO = WIDTH'(8'h1F);
    localparam logic [WIDTH-1:0] PAD_HI = {8'h80, {(WIDTH-8){1'b0}}};

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             pending_pad;
    logic [WIDTH-1:0] words   [DEPTH];
    logic [WIDTH-1:0] fin     [DEPTH];
    logic [WIDTH-1:0] pad_blk [DEPTH];
    logic [WIDTH-1:0] last_word;
    logic             full_n;
    logic             idx_top;

    assign full_n  = (int'(in_bytes) == NB);
    assign idx_top = (idx == IW'(DEPTH - 1));

    // First word received sits in the top slice of the packed block.
    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign block_out[(DEPTH-g)*WIDTH-1 -: WIDTH] = words[g];
    end

    // Final word: keep the valid low bytes, drop the rest, drop in 0x1F.
    always_comb begin
        last_word = '0;
        for (int k = 0; k < NB; k++) begin
            if (k < int'(in_bytes))
                last_word[8*k +: 8] = in_data[8*k +: 8];
            else if (k == int'(in_bytes))
                last_word[8*k +: 8] = 8'h1F;
        end
    end

    // Padded image of the whole block if the current word is the last one.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            fin[j] = '0;
            if (j < int'(idx))
                fin[j] = words[j];
            else if (j == int'(idx))
                fin[j] = last_word;
            else if (j == int'(idx) + 1 && full_n)
                fin[j] = PAD_LO;
        end
        if (!(full_n && idx_top))
            fin[DEPTH-1] = fin[DEPTH-1] | PAD_HI;
    end

    // Extra block emitted when the message exactly filled the last block.
    always_comb begin
        for (int j = 0; j < DEPTH; j++)
            pad_blk[j] = '0;
        pad_blk[0]       = PAD_LO;
        pad_blk[DEPTH-1] = pad_blk[DEPTH-1] | PAD_HI;
    end

    // Collect / present state machine with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COLLECT;
            idx         <= '0;
            pending_pad <= 1'b0;
            in_ready    <= 1'b1;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
            for (int j = 0; j < DEPTH; j++)
                words[j] <= '0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (in_valid) begin
                        if (in_last) begin
                            words       <= fin;
                            state       <= FULL;
                            in_ready    <= 1'b0;
                            block_valid <= 1'b1;
                            idx         <= '0;
                            if (full_n && idx_top) begin
                                pending_pad <= 1'b1;
                                block_last  <= 1'b0;
                            end else begin
                                block_last  <= 1'b1;
                            end
                        end else begin
                            words[idx] <= in_data;
                            if (idx_top) begin
                                state       <= FULL;
                                in_ready    <= 1'b0;
                                block_valid <= 1'b1;
                                block_last  <= 1'b0;
                                idx         <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                end
                FULL: begin
                    if (block_ready) begin
                        if (pending_pad) begin
                            words       <= pad_blk;
                            block_last  <= 1'b1;
                            pending_pad <= 1'b0;
                        end else begin
                            state       <= COLLECT;
                            in_ready    <= 1'b1;
                            block_valid <= 1'b0;
                            block_last  <= 1'b0;
                            idx         <= '0;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_pad_buffer.sv
// Directed bench for sipo_pad_buffer (WIDTH=64, DEPTH=21).
module tb_sipo_pad_buffer;

    localparam int W = 64;
    localparam int D = 21;
    localparam logic [63:0] HI80 = 64'h8000_0000_0000_0000;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic [3:0]     in_bytes;
    logic           in_ready;
    logic [D*W-1:0] block_out;
    logic           block_valid;
    logic           block_last;
    logic           block_ready;

    int checks   = 0;
    int failures = 0;

    sipo_pad_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .in_ready    (in_ready),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_last  (block_last),
        .block_ready (block_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready && in_last)
            assert (in_bytes <= 4'd8)
            else $error("illegal in_bytes %0d", in_bytes);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wd(int i);
        return block_out[(D-i)*W-1 -: W];
    endfunction

    function automatic logic [63:0] orr(int lo, int hi);
        logic [63:0] r = '0;
        for (int i = lo; i <= hi; i++)
            r = r | wd(i);
        return r;
    endfunction

    function automatic logic [63:0] dat(int i);
        return 64'h1111_2222_0000_0000 | 64'(i);
    endfunction

    task automatic send(input logic [63:0] d, input logic l,
                        input logic [3:0] n);
        in_data  = d;
        in_last  = l;
        in_bytes = n;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take();
        block_ready = 1'b1;
        @(posedge clk);
        #1;
        block_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_bytes = '0;
        block_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", block_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_out", |block_out, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // empty message
        send(64'hDEAD_BEEF_0000_0000, 1'b1, 4'd0);
        chk("e_valid", block_valid, 1);
        chk("e_last", block_last, 1);
        chk("e_w0", wd(0), 64'h1F);
        chk("e_mid", orr(1, 19), 0);
        chk("e_w20", wd(20), HI80);
        chk("e_ready", in_ready, 0);
        take();
        chk("e_done", block_valid, 0);
        chk("e_rdy2", in_ready, 1);

        // three bytes, garbage above must be dropped
        send(64'hFFFF_FFFF_FFAA_BBCC, 1'b1, 4'd3);
        chk("b3_w0", wd(0), 64'h0000_0000_1FAA_BBCC);
        chk("b3_w20", wd(20), HI80);
        chk("b3_last", block_last, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("b3_rdy", in_ready, 0);
        take();

        // 21 full words then a 7-byte last word
        for (int i = 0; i < D; i++) begin
            chk("f_rdy", in_ready, 1);
            send(dat(i), 1'b0, 4'd0);
        end
        chk("f_valid", block_valid, 1);
        chk("f_last", block_last, 0);
        chk("f_w0", wd(0), dat(0));
        chk("f_w20", wd(20), dat(20));
        take();
        send(64'h0123_4567_89AB_CDEF, 1'b1, 4'd7);
        chk("f2_w0", wd(0), 64'h1F23_4567_89AB_CDEF);
        chk("f2_mid", orr(1, 19), 0);
        chk("f2_w20", wd(20), HI80);
        chk("f2_last", block_last, 1);
        take();

        // message ends exactly on a block boundary
        for (int i = 0; i < D - 1; i++)
            send(dat(i + 40), 1'b0, 4'd0);
        send(64'h0102_0304_0506_0708, 1'b1, 4'd8);
        chk("x_valid", block_valid, 1);
        chk("x_last", block_last, 0);
        chk("x_w0", wd(0), dat(40));
        chk("x_w20", wd(20), 64'h0102_0304_0506_0708);
        take();
        chk("p_valid", block_valid, 1);
        chk("p_last", block_last, 1);
        chk("p_w0", wd(0), 64'h1F);
        chk("p_mid", orr(1, 19), 0);
        chk("p_w20", wd(20), HI80);
        take();
        chk("p_done", block_valid, 0);

        // 7-byte last word in the top slot merges 0x1F with 0x80
        for (int i = 0; i < D - 1; i++)
            send(dat(i + 80), 1'b0, 4'd0);
        send(64'hAABB_CCDD_EEFF_0011, 1'b1, 4'd7);
        chk("m_w20", wd(20), 64'h9FBB_CCDD_EEFF_0011);
        chk("m_last", block_last, 1);
        chk("m_w19", wd(19), dat(99));
        take();

        // stall with in_valid held, then reset mid-handoff
        send(dat(7), 1'b0, 4'd0);
        send(64'hFFFF_FFFF_FFFF_1234, 1'b1, 4'd2);
        in_data  = 64'h5555_5555_5555_5555;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("s_rdy", in_ready, 0);
            chk("s_w0", wd(0), dat(7));
            chk("s_w1", wd(1), 64'h0000_0000_001F_1234);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("r_valid", block_valid, 0);
        chk("r_ready", in_ready, 1);
        chk("r_out", |block_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(64'hFFFF_FFFF_FFFF_5566, 1'b1, 4'd2);
        chk("n_w0", wd(0), 64'h0000_0000_001F_5566);
        chk("n_mid", orr(1, 19), 0);
        chk("n_w20", wd(20), HI80);
        chk("n_last", block_last, 1);
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
